// File: rtl/decode_pkg.sv
// Shared opcode constants and instruction field helpers for the decode stage.
// Field helpers take the widths as arguments so any OPC_W/REG_W combination can use them.
package decode_pkg;

  localparam logic [31:0] OP_NOP = 32'd0;
  localparam logic [31:0] OP_ST  = 32'd14;
  localparam logic [31:0] OP_BR  = 32'd15;

  function automatic logic writes_rd(input logic [31:0] op);
    return !(op == OP_NOP || op == OP_ST || op == OP_BR);
  endfunction

  function automatic logic [31:0] fld_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Instruction layout is {opcode, rd, rs, rt}, MSB first.
  function automatic logic [31:0] fld_rt(input logic [31:0] instr, input int reg_w);
    return instr & fld_mask(reg_w);
  endfunction

  function automatic logic [31:0] fld_rs(input logic [31:0] instr, input int reg_w);
    return (instr >> reg_w) & fld_mask(reg_w);
  endfunction

  function automatic logic [31:0] fld_rd(input logic [31:0] instr, input int reg_w);
    return (instr >> (2 * reg_w)) & fld_mask(reg_w);
  endfunction

  function automatic logic [31:0] fld_op(input logic [31:0] instr, input int opc_w,
                                        input int reg_w);
    return (instr >> (3 * reg_w)) & fld_mask(opc_w);
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending-write scoreboard with one set port, one clear port and
// two hazard queries. Register 0 is never busy.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int REG_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_addr,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_addr,
  input  logic [REG_W-1:0] qa_addr,
  output logic             qa_busy,
  input  logic [REG_W-1:0] qb_addr,
  output logic             qb_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && clr_addr != '0) busy_d[clr_addr] = 1'b0;
    // Set is applied last so a new writer keeps ownership over a same-cycle writeback.
    if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a plain flop vector, so it is fully reset; a true RAM would not be.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign qa_busy = busy_q[qa_addr];
  assign qb_busy = busy_q[qb_addr];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field split, operand read, scoreboard stall, one output slot.
// Define DECODE_BYPASS_EN to forward a same-cycle writeback into the issuing operands.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = $clog2(NREGS),
  parameter int INSTR_W = OPC_W + 3 * REG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [REG_W-1:0]   rf_rs_addr,
  output logic [REG_W-1:0]   rf_rt_addr,
  input  logic [DATA_W-1:0]  rf_rs_data,
  input  logic [DATA_W-1:0]  rf_rt_data,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   rdidx,
  output logic [DATA_W-1:0]  rsval,
  output logic [DATA_W-1:0]  rtval
);

  logic [OPC_W-1:0]  op;
  logic [REG_W-1:0]  rd, rs, rt;
  logic              rs_busy, rt_busy, rs_haz, rt_haz, accept;
  logic [DATA_W-1:0] rs_val, rt_val;

  logic              out_valid_q, out_valid_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [REG_W-1:0]  rdidx_q, rdidx_d;
  logic [DATA_W-1:0] rsval_q, rsval_d, rtval_q, rtval_d;

  assign op = OPC_W'(fld_op(32'(in_instr), OPC_W, REG_W));
  assign rd = REG_W'(fld_rd(32'(in_instr), REG_W));
  assign rs = REG_W'(fld_rs(32'(in_instr), REG_W));
  assign rt = REG_W'(fld_rt(32'(in_instr), REG_W));

  assign rf_rs_addr = rs;
  assign rf_rt_addr = rt;

  decode_scoreboard #(.NREGS(NREGS), .REG_W(REG_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && writes_rd(32'(op))),
    .set_addr (rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .qa_addr  (rs),
    .qa_busy  (rs_busy),
    .qb_addr  (rt),
    .qb_busy  (rt_busy)
  );

`ifdef DECODE_BYPASS_EN
  logic rs_byp, rt_byp;
  assign rs_byp = wb_valid && wb_addr == rs && rs != '0;
  assign rt_byp = wb_valid && wb_addr == rt && rt != '0;
  assign rs_haz = rs_busy && !rs_byp;
  assign rt_haz = rt_busy && !rt_byp;
  assign rs_val = (rs == '0) ? '0 : (rs_byp ? wb_data : rf_rs_data);
  assign rt_val = (rt == '0) ? '0 : (rt_byp ? wb_data : rf_rt_data);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign rs_haz = rs_busy;
  assign rt_haz = rt_busy;
  assign rs_val = (rs == '0) ? '0 : rf_rs_data;
  assign rt_val = (rt == '0) ? '0 : rf_rt_data;
`endif

  assign in_ready = !rst && !(rs_haz || rt_haz) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    rdidx_d     = rdidx_q;
    rsval_d     = rsval_q;
    rtval_d     = rtval_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = op;
      rdidx_d     = rd;
      rsval_d     = rs_val;
      rtval_d     = rt_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rdidx_q     <= '0;
      rsval_q     <= '0;
      rtval_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rdidx_q     <= rdidx_d;
      rsval_q     <= rsval_d;
      rtval_q     <= rtval_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign rdidx     = rdidx_q;
  assign rsval     = rsval_q;
  assign rtval     = rtval_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow DECODE_BYPASS_EN.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic [3:0]  rf_rs_addr, rf_rt_addr;
  logic [15:0] rf_rs_data, rf_rt_data;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  opcode, rdidx;
  logic [15:0] rsval, rtval;

  logic [15:0] rf [16];
  int checks   = 0;
  int failures = 0;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .rf_rs_addr (rf_rs_addr),
    .rf_rt_addr (rf_rt_addr),
    .rf_rs_data (rf_rs_data),
    .rf_rt_data (rf_rt_data),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .opcode     (opcode),
    .rdidx      (rdidx),
    .rsval      (rsval),
    .rtval      (rtval)
  );

  always #5 clk = ~clk;

  assign rf_rs_data = rf[rf_rs_addr];
  assign rf_rt_data = rf[rf_rt_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the model register file takes any writeback on the edge.
  task automatic step();
    @(posedge clk);
    if (wb_valid && wb_addr != 4'd0) rf[wb_addr] = wb_data;
    #1;
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, rd, rs, rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [31:0] busy_vec();
    return 32'(dut.u_sb.busy_q);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h0100);
    rf[0] = 16'hFFFF;
    rf[1] = 16'h0005;
    rf[2] = 16'h0007;
    rst = 1'b1; in_valid = 1'b1; in_instr = ins(4'd1, 4'd3, 4'd1, 4'd2);
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_fields", {opcode, rdidx, 8'h00} | 32'(rsval) | 32'(rtval), 0);
    check("rst_busy", busy_vec(), 0);
    step(); step();
    rst = 1'b0;

    // ADD r3 <- r1, r2.
    #1;
    check("add_in_ready", 32'(in_ready), 1);
    step();
    check("add_valid", 32'(out_valid), 1);
    check("add_op", 32'(opcode), 1);
    check("add_rd", 32'(rdidx), 3);
    check("add_rs", 32'(rsval), 16'h0005);
    check("add_rt", 32'(rtval), 16'h0007);
    check("add_busy3", busy_vec(), 32'h0008);

    // SUB r5 <- r3, r1 depends on the pending r3.
    in_instr = ins(4'd2, 4'd5, 4'd3, 4'd1);
    #1;
    check("dep_stall0", 32'(in_ready), 0);
    step();
    check("dep_drained", 32'(out_valid), 0);
    check("dep_stall1", 32'(in_ready), 0);
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'h00AA;
    #1;
`ifdef DECODE_BYPASS_EN
    check("dep_wb_ready", 32'(in_ready), 1);
    step();
    wb_valid = 1'b0;
`else
    check("dep_wb_ready", 32'(in_ready), 0);
    step();
    wb_valid = 1'b0;
    #1;
    check("dep_next_ready", 32'(in_ready), 1);
    step();
`endif
    check("dep_valid", 32'(out_valid), 1);
    check("dep_op", 32'(opcode), 2);
    check("dep_rd", 32'(rdidx), 5);
    check("dep_rs", 32'(rsval), 16'h00AA);
    check("dep_rt", 32'(rtval), 16'h0005);

    // Back-pressure for three cycles with the next instruction waiting.
    out_ready = 1'b0;
    in_instr = ins(4'd3, 4'd6, 4'd1, 4'd2);
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 16'h0055;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 0);
      step();
      wb_valid = 1'b0;
      check("stall_hold", {opcode, rdidx, rsval, 1'b0, out_valid, 6'd0}, {4'd2, 4'd5, 16'h00AA, 8'h40});
    end
    out_ready = 1'b1;
    #1;
    check("rel_ready", 32'(in_ready), 1);
    step();
    check("rel_a", {opcode, rdidx, rsval}, {4'd3, 4'd6, 16'h0005});
    check("rel_a_rt", 32'(rtval), 16'h0007);
    in_instr = ins(4'd4, 4'd7, 4'd2, 4'd1);
    #1;
    check("b2b_ready", 32'(in_ready), 1);
    step();
    check("b2b_b", {opcode, rdidx, rsval}, {4'd4, 4'd7, 16'h0007});
    in_valid = 1'b0;
    step();
    check("b2b_drain", 32'(out_valid), 0);

    // r0 sources read as zero; writeback to r0 is ignored.
    in_valid = 1'b1;
    in_instr = ins(4'd1, 4'd8, 4'd0, 4'd0);
    wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 16'h1234;
    #1;
    check("r0_ready", 32'(in_ready), 1);
    step();
    wb_valid = 1'b0;
    check("r0_rs", 32'(rsval), 0);
    check("r0_rt", 32'(rtval), 0);
    check("r0_busy", busy_vec(), 32'h01C0);

    // New writer of r4 in the same cycle as a writeback to r4.
    in_instr = ins(4'd1, 4'd4, 4'd1, 4'd2);
    wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 16'h0044;
    step();
    wb_valid = 1'b0;
    in_valid = 1'b0;
    check("setwin_busy", busy_vec(), 32'h01D0);
    check("setwin_rd", 32'(rdidx), 4);

    // Asynchronous reset while the slot is full.
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_busy", busy_vec(), 0);
    check("arst_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_instr = ins(4'd2, 4'd9, 4'd4, 4'd6);
    #1;
    check("post_rst_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("post_rst", {opcode, rdidx, rsval}, {4'd2, 4'd9, 16'h0044});
    check("post_rst_rt", 32'(rtval), 16'h0600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
